fifo_frame_reader: RTL and testbench
====================================

# fifo_frame_reader

- Read-side consumer of the 16-bit sample FIFO (16 x 65536, non-FWFT, common clock).
- Drains samples from the FIFO and emits them as fixed-length frames on a valid/ready stream: one header word, then FRAME_LEN payload words, with TX_LAST on the final word.
- Handles FIFO read latency and downstream backpressure with credit-limited reads into a small skid buffer.
- Sits between the FIFO Q port and the readout/communication path.

## Interface
- FRAME_LEN, 256: payload words per frame. Range 1..4095.
- RD_LAT, 1: cycles from FIFO_RE high to valid FIFO_Q. Range 1..2.
- SKID_DEPTH, 4: skid buffer entries. Must be ≥ RD_LAT+2.
- CLK  in  1  system clock; all logic rising-edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  permits starting a new frame; sampled only in IDLE.
- FIFO_RE  out  1  FIFO read enable, active-high.
- FIFO_Q  in  16  FIFO read data, valid RD_LAT cycles after FIFO_RE.
- FIFO_EMPTY  in  1  FIFO empty flag.
- TX_DATA  out  16  stream data.
- TX_VALID  out  1  stream valid.
- TX_READY  in  1  stream ready from downstream.
- TX_LAST  out  1  marks the last payload word of a frame.
- BUSY  out  1  high in any state other than IDLE.
- FRAME_CNT  out  12  count of completed frames; wraps 4095→0.

## Operation
- States:
  - IDLE → HEADER when ENABLE=1 and FIFO_EMPTY=0.
  - HEADER → PAYLOAD on a header handshake.
  - PAYLOAD → IDLE on the handshake of payload word FRAME_LEN-1.
- Handshake: a word transfers when TX_VALID=1 and TX_READY=1 in the same cycle.
  - Once TX_VALID is raised, TX_VALID and TX_DATA hold until that transfer.
- Header word: TX_DATA = {4'hA, FRAME_CNT}. TX_VALID=1 for the whole HEADER state. TX_LAST=0.
- Payload words: TX_DATA = skid buffer head. TX_VALID = skid buffer not empty. TX_LAST=1 only on payload word FRAME_LEN-1.
- Read issue: FIFO_RE = (state≠IDLE) & ~FIFO_EMPTY & (rd_cnt<FRAME_LEN) & (occupancy+inflight < SKID_DEPTH).
  - rd_cnt resets to 0 on entering HEADER.
  - Reads may be issued during HEADER; data is prefetched into the skid buffer.
- inflight counts reads issued whose data has not yet arrived (0..RD_LAT). Each returned FIFO_Q is pushed into the skid buffer.
- Simultaneous push and pop: occupancy is unchanged and data order is preserved.
- The skid buffer never overflows. The credit rule guarantees it; the bench asserts it.
- FIFO goes empty mid-frame: FIFO_RE=0 and TX_VALID drops once the buffer drains. The frame resumes when data returns. No timeout, no abort.
- ENABLE deasserted mid-frame: the current frame completes. No new frame starts.
- FRAME_CNT increments on the last payload handshake; the header already carries the pre-increment value.
- Reset (async, any state): state=IDLE, skid buffer and all counters cleared, in-flight reads discarded.
  - All outputs 0: FIFO_RE, TX_VALID, TX_LAST, TX_DATA, BUSY, FRAME_CNT.

## Timing
- All outputs are registered except FIFO_RE and TX_VALID. These are combinational from registered state and the current FIFO_EMPTY / TX_READY.
- IDLE→HEADER: the header is valid the cycle after the ENABLE & ~FIFO_EMPTY condition.
- Streaming: with TX_READY=1 and the FIFO non-empty, payload runs at 1 word/cycle after the initial RD_LAT fill.
  - A frame occupies FRAME_LEN+1 transfer cycles. One IDLE cycle separates frames.
- First payload word is valid no earlier than RD_LAT cycles after the first FIFO_RE.
- rd_cnt is 12 bits and saturates at FRAME_LEN. tx_cnt is 12 bits and is compared against FRAME_LEN-1.

## Structure
- Package fifo_frame_pkg:
  - state enum (IDLE, HEADER, PAYLOAD)
  - HDR_TAG = 4'hA
  - counter width constant CNT_W = 12
- Sub-module fifo_rd_skid: SKID_DEPTH×16 circular buffer.
  - Ports: push/pop/data_in/head/occupancy.
  - Read latency is handled by an RD_LAT-stage valid shift register in the parent.

## Test plan
- FRAME_LEN=4, FIFO preloaded with 0x0001..0x0008, TX_READY=1, ENABLE=1 → two frames of 0xA000,1,2,3,4 and 0xA001,5,6,7,8. TX_LAST on 4 and 8; FRAME_CNT=2.
- Random TX_READY (50%) over 1000 samples → output equals FIFO order with no loss or duplication; skid occupancy never exceeds SKID_DEPTH.
- FIFO empties after word 2 of a 4-word frame and is refilled 20 cycles later → TX_VALID low during the gap; frame completes with the correct data and TX_LAST.
- ENABLE dropped during payload word 1 → frame completes, returns to IDLE, and no further header is emitted while the FIFO holds data.
- RESET_N asserted mid-payload with reads in flight → all outputs 0 immediately; after release the next frame header is 0xA000.
- RD_LAT=2, TX_READY=1 → sustained 1 word/cycle throughout payload.

Source files
------------

// File: rtl/fifo_frame_pkg.sv
// Shared types and constants for the FIFO frame reader: FSM states, header tag
// and counter width.
package fifo_frame_pkg;

    localparam int         CNT_W   = 12;
    localparam logic [3:0] HDR_TAG = 4'hA;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Small circular skid buffer that holds FIFO read data until the stream accepts it.
// The head word is kept in its own register, so the stream data comes straight from a flop.
module fifo_rd_skid #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [W-1:0]     head_q, head_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
        head_d   = '0;
        wr_ptr_d = push_i ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i ? next_ptr(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
        // An incoming word becomes the head when nothing older remains after this pop.
        if (occ_d != '0) begin
            if ((occ_q == '0) || (pop_i && (occ_q == OCC_W'(1))))
                head_d = data_i;
            else
                head_d = mem_q[rd_ptr_d];
        end
    end

    // NOTE: the storage array has no reset; the cleared pointers and occupancy make stale entries unreachable.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            head_q   <= head_d;
        end
    end

    assign head_o      = head_q;
    assign occupancy_o = occ_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains the sample FIFO into fixed-length frames (header + FRAME_LEN payload words)
// on a valid/ready stream, using credit-limited reads into a skid buffer.
module fifo_frame_reader
    import fifo_frame_pkg::*;
#(
    parameter int FRAME_LEN  = 256,
    parameter int RD_LAT     = 1,
    parameter int SKID_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    output logic             fifo_re_o,
    input  logic [15:0]      fifo_q_i,
    input  logic             fifo_empty_i,
    output logic [15:0]      tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic             tx_last_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] frame_cnt_o
);

    localparam int               OCC_W    = $clog2(SKID_DEPTH + 1);
    localparam int               SUM_W    = $clog2(SKID_DEPTH + RD_LAT + 1);
    localparam logic [CNT_W-1:0] LEN      = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_e           state_q;
    logic [CNT_W-1:0] rd_cnt_q, tx_cnt_q, frame_cnt_q;
    logic             last_q;
    logic [RD_LAT-1:0] vld_q;
    logic [SUM_W-1:0] inflight;
    logic [OCC_W-1:0] occupancy;
    logic [15:0]      skid_head;
    logic             push, pop, handshake, credit_ok;

    // vld_q[0] is the newest read; the oldest bit marks FIFO_Q valid this cycle.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight += SUM_W'(vld_q[i]);
    end

    assign credit_ok  = (SUM_W'(occupancy) + inflight) < SUM_W'(SKID_DEPTH);
    assign fifo_re_o  = (state_q != IDLE) && !fifo_empty_i && (rd_cnt_q < LEN) && credit_ok;
    assign push       = vld_q[RD_LAT-1];
    assign tx_valid_o = (state_q == HEADER) || ((state_q == PAYLOAD) && (occupancy != '0));
    assign handshake  = tx_valid_o && tx_ready_i;
    assign pop        = (state_q == PAYLOAD) && handshake;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) vld_q <= '0;
        else          vld_q <= RD_LAT'({vld_q, fifo_re_o});
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            rd_cnt_q    <= '0;
            tx_cnt_q    <= '0;
            frame_cnt_q <= '0;
            last_q      <= 1'b0;
        end else begin
            if (fifo_re_o) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            case (state_q)
                IDLE: begin
                    if (enable_i && !fifo_empty_i) begin
                        state_q  <= HEADER;
                        rd_cnt_q <= '0;
                        tx_cnt_q <= '0;
                        last_q   <= 1'b0;
                    end
                end
                HEADER: begin
                    if (handshake) begin
                        state_q <= PAYLOAD;
                        last_q  <= (LAST_IDX == '0);
                    end
                end
                PAYLOAD: begin
                    if (handshake) begin
                        if (tx_cnt_q == LAST_IDX) begin
                            state_q     <= IDLE;
                            tx_cnt_q    <= '0;
                            last_q      <= 1'b0;
                            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                        end else begin
                            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                            last_q   <= ((tx_cnt_q + CNT_W'(1)) == LAST_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fifo_rd_skid #(
        .DEPTH (SKID_DEPTH),
        .W     (16)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (push),
        .pop_i       (pop),
        .data_i      (fifo_q_i),
        .head_o      (skid_head),
        .occupancy_o (occupancy)
    );

    // Skid head reads as zero when empty, so idle outputs stay clean.
    assign tx_data_o   = (state_q == HEADER) ? {HDR_TAG, frame_cnt_q} : skid_head;
    assign tx_last_o   = last_q;
    assign busy_o      = (state_q != IDLE);
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: two instances (RD_LAT 1 and 2) fed by FIFO models,
// checked against an in-order scoreboard of expected frames.
module tb_fifo_frame_reader;

    localparam int FL_A = 4, LAT_A = 1, SD_A = 4;
    localparam int FL_B = 8, LAT_B = 2, SD_B = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        enable_a = 1'b0, ready_a = 1'b0, enable_b = 1'b0, ready_b = 1'b1;
    logic        fifo_re_a, fifo_empty_a, tx_valid_a, tx_last_a, busy_a;
    logic        fifo_re_b, fifo_empty_b, tx_valid_b, tx_last_b, busy_b;
    logic [15:0] q_a = '0, q_b = '0, s1_b = '0, tx_data_a, tx_data_b;
    logic [11:0] frame_cnt_a, frame_cnt_b;

    // FIFO models: fixed memory per instance, written by the stimulus, read by the DUT.
    logic [15:0] mem [2][16384];
    int wr_ptr [2];
    int rd_a = 0, rd_b = 0;

    assign fifo_empty_a = (wr_ptr[0] == rd_a);
    assign fifo_empty_b = (wr_ptr[1] == rd_b);

    always @(posedge clk) begin
        if (fifo_re_a) begin
            q_a  <= mem[0][rd_a];
            rd_a <= rd_a + 1;
        end
    end

    always @(posedge clk) begin
        if (fifo_re_b) begin
            s1_b <= mem[1][rd_b];
            rd_b <= rd_b + 1;
        end
        q_b <= s1_b;
    end

    fifo_frame_reader #(.FRAME_LEN(FL_A), .RD_LAT(LAT_A), .SKID_DEPTH(SD_A)) u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable_a), .fifo_re_o(fifo_re_a),
        .fifo_q_i(q_a), .fifo_empty_i(fifo_empty_a), .tx_data_o(tx_data_a),
        .tx_valid_o(tx_valid_a), .tx_ready_i(ready_a), .tx_last_o(tx_last_a),
        .busy_o(busy_a), .frame_cnt_o(frame_cnt_a)
    );

    fifo_frame_reader #(.FRAME_LEN(FL_B), .RD_LAT(LAT_B), .SKID_DEPTH(SD_B)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable_b), .fifo_re_o(fifo_re_b),
        .fifo_q_i(q_b), .fifo_empty_i(fifo_empty_b), .tx_data_o(tx_data_b),
        .tx_valid_o(tx_valid_b), .tx_ready_i(ready_b), .tx_last_o(tx_last_b),
        .busy_o(busy_b), .frame_cnt_o(frame_cnt_b)
    );

    int n_pass = 0, n_total = 0, cyc = 0;

    // Scoreboard: position inside the frame (0 = header), frames done, next FIFO index.
    int pos [2], fk [2], exp_idx [2], last_hs [2];
    logic stall [2];
    logic [15:0] stall_d [2], smp_data [2], last_hs_data [2];
    logic smp_valid [2], smp_last [2], smp_re [2], smp_busy [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic push(input int u, input logic [15:0] v);
        mem[u][wr_ptr[u]] = v;
        wr_ptr[u]++;
    endtask

    task automatic monitor(input int u);
        logic v, r, l, re, emp, bsy;
        logic [15:0] d, exp_d;
        logic [11:0] fc;
        int occ, fl, sd;
        if (u == 0) begin
            v = tx_valid_a; r = ready_a; l = tx_last_a; re = fifo_re_a; emp = fifo_empty_a;
            bsy = busy_a; d = tx_data_a; fc = frame_cnt_a; occ = int'(u_dut_a.occupancy);
            fl = FL_A; sd = SD_A;
        end else begin
            v = tx_valid_b; r = ready_b; l = tx_last_b; re = fifo_re_b; emp = fifo_empty_b;
            bsy = busy_b; d = tx_data_b; fc = frame_cnt_b; occ = int'(u_dut_b.occupancy);
            fl = FL_B; sd = SD_B;
        end
        smp_valid[u] = v; smp_data[u] = d; smp_last[u] = l; smp_re[u] = re; smp_busy[u] = bsy;
        if (!rst_n) begin
            pos[u] = 0; fk[u] = 0; stall[u] = 1'b0;
            exp_idx[u] = (u == 0) ? rd_a : rd_b;
            return;
        end
        check($sformatf("u%0d_occ_le_depth", u), 32'(occ <= sd), 32'd1);
        check($sformatf("u%0d_re_not_empty", u), 32'(!(re && emp)), 32'd1);
        if (stall[u]) begin
            check($sformatf("u%0d_hold_valid", u), 32'(v), 32'd1);
            check($sformatf("u%0d_hold_data", u), 32'(d), 32'(stall_d[u]));
        end
        if (v && r) begin
            if (pos[u] == 0) begin
                exp_d = {4'hA, 12'(fk[u])};
                check($sformatf("u%0d_frame_cnt_at_hdr", u), 32'(fc), 32'(12'(fk[u])));
            end else begin
                exp_d = mem[u][exp_idx[u]];
            end
            check($sformatf("u%0d_data_pos%0d", u, pos[u]), 32'(d), 32'(exp_d));
            check($sformatf("u%0d_last_pos%0d", u, pos[u]), 32'(l), 32'(pos[u] == fl));
            if (u == 1 && pos[1] >= 2)
                check("u1_payload_gap", 32'(cyc - last_hs[1]), 32'd1);
            if (pos[u] != 0) exp_idx[u]++;
            last_hs_data[u] = d;
            last_hs[u] = cyc;
            pos[u]++;
            if (pos[u] > fl) begin
                pos[u] = 0;
                fk[u]++;
            end
        end
        stall[u] = v && !r;
        stall_d[u] = d;
    endtask

    // One clock: observe both instances on the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        monitor(0);
        monitor(1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic        ready;
        logic [15:0] data;
        logic        last;
    } vec_t;

    vec_t tab [12];

    initial begin
        int n, cnt;
        wr_ptr[0] = 0;
        wr_ptr[1] = 0;
        tab[0]  = '{1'b0, 16'hA000, 1'b0};
        tab[1]  = '{1'b1, 16'hA000, 1'b0};
        tab[2]  = '{1'b1, 16'h0001, 1'b0};
        tab[3]  = '{1'b0, 16'h0002, 1'b0};
        tab[4]  = '{1'b1, 16'h0002, 1'b0};
        tab[5]  = '{1'b1, 16'h0003, 1'b0};
        tab[6]  = '{1'b1, 16'h0004, 1'b1};
        tab[7]  = '{1'b1, 16'hA001, 1'b0};
        tab[8]  = '{1'b1, 16'h0005, 1'b0};
        tab[9]  = '{1'b1, 16'h0006, 1'b0};
        tab[10] = '{1'b1, 16'h0007, 1'b0};
        tab[11] = '{1'b1, 16'h0008, 1'b1};

        // Reset state
        tick();
        tick();
        check("rst_fifo_re", 32'(fifo_re_a), 32'd0);
        check("rst_tx_valid", 32'(tx_valid_a), 32'd0);
        check("rst_tx_last", 32'(tx_last_a), 32'd0);
        check("rst_tx_data", 32'(tx_data_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt_a), 32'd0);
        check("rst_b_valid", 32'(tx_valid_b), 32'd0);
        rst_n = 1'b1;
        tick();

        // Two 4-word frames from a preloaded FIFO, with a couple of stalls
        for (int i = 1; i <= 8; i++) push(0, 16'(i));
        ready_a = 1'b0;
        enable_a = 1'b1;
        tick();
        check("hdr_not_same_cycle", 32'(smp_valid[0]), 32'd0);
        tick();
        check("hdr_next_cycle", 32'(smp_valid[0]), 32'd1);
        for (int i = 0; i < 12; i++) begin
            ready_a = tab[i].ready;
            n = 0;
            do begin
                tick();
                n++;
            end while (!smp_valid[0] && n < 20);
            check($sformatf("tab%0d_valid", i), 32'(smp_valid[0]), 32'd1);
            check($sformatf("tab%0d_data", i), 32'(smp_data[0]), 32'(tab[i].data));
            check($sformatf("tab%0d_last", i), 32'(smp_last[0]), 32'(tab[i].last));
        end
        repeat (3) tick();
        check("two_frames_cnt", 32'(frame_cnt_a), 32'd2);
        check("two_frames_idle", 32'(busy_a), 32'd0);

        // 1000 random samples with 50% ready
        for (int i = 0; i < 1000; i++) push(0, 16'($urandom));
        n = 0;
        while (fk[0] < 252 && n < 20000) begin
            ready_a = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        ready_a = 1'b1;
        check("rand_frames_done", 32'(fk[0]), 32'd252);
        repeat (3) tick();
        check("rand_frame_cnt", 32'(frame_cnt_a), 32'd252);
        check("rand_all_consumed", 32'(exp_idx[0]), 32'(wr_ptr[0]));

        // FIFO runs dry after payload word 2, refilled 20 cycles later
        push(0, 16'h1234);
        push(0, 16'h5678);
        n = 0;
        while (pos[0] != 3 && n < 50) begin tick(); n++; end
        check("gap_reach_word2", 32'(pos[0]), 32'd3);
        cnt = 0;
        repeat (20) begin
            tick();
            if (smp_valid[0]) cnt++;
        end
        check("gap_valid_low", 32'(cnt), 32'd0);
        check("gap_still_busy", 32'(smp_busy[0]), 32'd1);
        push(0, 16'h9ABC);
        push(0, 16'hDEF0);
        n = 0;
        while (fk[0] < 253 && n < 50) begin tick(); n++; end
        check("gap_frame_done", 32'(fk[0]), 32'd253);

        // ENABLE dropped during payload: frame finishes, no new header
        for (int i = 0; i < 8; i++) push(0, 16'h4000 + 16'(i));
        n = 0;
        while (pos[0] != 1 && n < 20) begin tick(); n++; end
        check("en_drop_hdr_sent", 32'(pos[0]), 32'd1);
        enable_a = 1'b0;
        n = 0;
        while (fk[0] < 254 && n < 60) begin tick(); n++; end
        check("en_drop_frame_done", 32'(fk[0]), 32'd254);
        cnt = 0;
        repeat (30) begin
            tick();
            if (smp_busy[0] || smp_valid[0]) cnt++;
        end
        check("en_drop_no_new_frame", 32'(cnt), 32'd0);
        check("en_drop_fifo_left", 32'(wr_ptr[0] - rd_a), 32'd4);

        // Reset mid-payload with reads in flight
        for (int i = 0; i < 4; i++) push(0, 16'h5000 + 16'(i));
        enable_a = 1'b1;
        n = 0;
        while (!(pos[0] >= 2 && smp_re[0]) && n < 40) begin tick(); n++; end
        check("rst_mid_reached", 32'(pos[0] >= 2 && smp_re[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_fifo_re", 32'(fifo_re_a), 32'd0);
        check("rst_mid_valid", 32'(tx_valid_a), 32'd0);
        check("rst_mid_last", 32'(tx_last_a), 32'd0);
        check("rst_mid_data", 32'(tx_data_a), 32'd0);
        check("rst_mid_busy", 32'(busy_a), 32'd0);
        check("rst_mid_frame_cnt", 32'(frame_cnt_a), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
        while (pos[0] != 1 && n < 20) begin tick(); n++; end
        check("post_rst_hdr", 32'(last_hs_data[0]), 32'hA000);
        enable_a = 1'b0;
        n = 0;
        while (fk[0] < 1 && n < 60) begin tick(); n++; end
        check("post_rst_frame_done", 32'(fk[0]), 32'd1);

        // RD_LAT=2 instance: payload must stream at one word per cycle
        for (int i = 0; i < 16; i++) push(1, 16'h7000 + 16'(i));
        ready_b = 1'b1;
        enable_b = 1'b1;
        n = 0;
        while (fk[1] < 2 && n < 200) begin tick(); n++; end
        enable_b = 1'b0;
        check("lat2_frames_done", 32'(fk[1]), 32'd2);
        repeat (3) tick();
        check("lat2_frame_cnt", 32'(frame_cnt_b), 32'd2);
        check("lat2_idle", 32'(busy_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
